// File: rtl/ms9_slave_feeder_pkg.sv
// ============================================================================
// Module   : ms9_feeder_types (package)
// Purpose  : Shared types and constants for the ms9 slave feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ms9_feeder_types;

    localparam int MS9_WORD_W = 32;

    typedef enum logic [1:0] {
        SEC_IDLE = 2'd0,
        SEC_EMIT = 2'd1,
        SEC_GAP  = 2'd2
    } Sections;

endpackage

`default_nettype wire

// File: rtl/ms9_slave_feeder_fifo.sv
// ============================================================================
// Module   : ms9_feeder_fifo
// Purpose  : DEPTH-entry synchronous FIFO with clear; caller guards push/pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms9_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ms9_slave_feeder.sv
// ============================================================================
// Module   : ms9_slave_feeder
// Purpose  : Buffers producer words and emits them as value+sync pulses,
//            at most one per PERIOD cycles. Optional MS9_FEEDER_STATS_EN
//            adds emit/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms9_slave_feeder
    import ms9_feeder_types::*;
#(
    parameter int DEPTH  = 4,
    parameter int PERIOD = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [MS9_WORD_W-1:0]  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic signed [MS9_WORD_W-1:0]  out_data,
    output logic                          out_sync,
`ifdef MS9_FEEDER_STATS_EN
    output logic [31:0]                   emit_count,
    output logic [31:0]                   stall_count,
`endif
    output logic [$clog2(DEPTH):0]        level
);

    localparam int GAP_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    Sections                 section, section_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic [MS9_WORD_W-1:0]   head;
    logic [MS9_WORD_W-1:0]   out_data_nxt;
    logic                    emit;
    logic                    push;

    ms9_feeder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MS9_WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (emit),
        .wdata (in_data),
        .head  (head),
        .level (level)
    );

    // Ready looks only at the registered level, so a same-edge pop never frees a slot
    assign in_ready = (level != ($clog2(DEPTH)+1)'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign emit     = (gap_cnt == '0) && (level != '0) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section  <= SEC_IDLE;
            gap_cnt  <= '0;
            out_data <= '0;
            out_sync <= 1'b0;
        end else begin
            section  <= section_nxt;
            gap_cnt  <= gap_nxt;
            out_data <= out_data_nxt;
            out_sync <= emit;
        end
    end

    always_comb begin
        section_nxt = SEC_IDLE;
        gap_nxt     = '0;
        if (flush) begin
            section_nxt = SEC_IDLE;
            gap_nxt     = '0;
        end else if (emit) begin
            section_nxt = SEC_EMIT;
            gap_nxt     = GAP_W'(PERIOD - 1);
        end else begin
            gap_nxt     = (gap_cnt != '0) ? gap_cnt - 1'b1 : '0;
            section_nxt = (gap_nxt != '0) ? SEC_GAP : SEC_IDLE;
        end
    end

    always_comb begin
        out_data_nxt = out_data;
        if (emit) out_data_nxt = head;
    end

`ifdef MS9_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emit_count  <= '0;
            stall_count <= '0;
        end else if (flush) begin
            emit_count  <= '0;
            stall_count <= '0;
        end else begin
            emit_count  <= emit_count + 32'(emit);
            stall_count <= stall_count + 32'(in_valid && !in_ready);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ms9_slave_feeder.sv
// ============================================================================
// Module   : tb_ms9_slave_feeder
// Purpose  : Directed and randomized checks of ms9_slave_feeder against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ms9_slave_feeder;

    localparam int DEPTH  = 4;
    localparam int PERIOD = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic signed [31:0] out_data;
    logic               out_sync;
    logic [2:0]         level;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents, last emitted word, cycles since emission
    logic [31:0] mq[$];
    logic [31:0] m_data;
    bit          m_sync;
    int          since;

    ms9_slave_feeder #(
        .DEPTH  (DEPTH),
        .PERIOD (PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_sync (out_sync),
`ifdef MS9_FEEDER_STATS_EN
        .emit_count  (),
        .stall_count (),
`endif
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = '0;
        m_sync = 1'b0;
        since  = PERIOD;
    endtask

    task automatic check_outputs();
        check("out_sync", {31'd0, out_sync}, {31'd0, m_sync});
        check("out_data", out_data, m_data);
        check("level", {29'd0, level}, mq.size());
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs
    task automatic step(input bit v, input logic [31:0] d, input bit f, output bit accepted);
        bit ready;
        in_valid = v;
        in_data  = d;
        flush    = f;
        #1;
        ready = (mq.size() < DEPTH);
        check("in_ready", {31'd0, in_ready}, {31'd0, ready});
        accepted = v && ready && !f;
        if (f) begin
            mq.delete();
            m_sync = 1'b0;
            since  = PERIOD;
        end else begin
            if (since >= PERIOD && mq.size() > 0) begin
                m_data = mq.pop_front();
                m_sync = 1'b1;
                since  = 1;
            end else begin
                m_sync = 1'b0;
                if (since < PERIOD) since++;
            end
            if (accepted) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, acc);
    endtask

    // Producer holds a word until it is taken, with a cycle bound
    task automatic push_word(input logic [31:0] d);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, d, 1'b0, acc);
            tries++;
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sync", {31'd0, out_sync}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Single word, one-cycle latency
        push_word(32'h0000_0007);
        idle(4);

        // Negative word passes untouched
        push_word(32'hFFFF_FFFF);
        idle(4);

        // Back-to-back burst spaced by PERIOD
        push_word(32'd10);
        push_word(32'd20);
        push_word(32'd30);
        idle(10);

        // Overflow: producer stalls on full FIFO
        for (int i = 1; i <= 6; i++) push_word(32'(100 + i));
        idle(20);

        // Flush with a concurrent push
        push_word(32'd41);
        push_word(32'd42);
        push_word(32'd43);
        step(1'b1, 32'd99, 1'b1, acc);
        idle(6);

        // Async reset during cooldown with buffered words
        push_word(32'd51);
        push_word(32'd52);
        push_word(32'd53);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_out_sync", {31'd0, out_sync}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_level", {29'd0, level}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 3, acc);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
